// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: requester select,
// priority state and the byte-to-word address shift.
package mem_arb_pkg;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_HST = 1'b1
   } port_e;

   typedef enum logic {
      PRI_CPU = 1'b0,
      PRI_HST = 1'b1
   } pri_e;

   // One memory word is 8 bytes, so byte address >> 3 gives the word address.
   localparam int WORD_SHIFT = 3;

endpackage

// File: rtl/arb_pri_fsm.sv
// Priority FSM for the memory port arbiter. Counts consecutive stalled
// host-request cycles and hands priority to the host once the count reaches
// MAX_WAIT; priority returns to the CPU the cycle after the host is granted.
// The current priority is exposed on pri_o.
module arb_pri_fsm
   import mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic hst_req_i,
   input  logic hst_gnt_i,
   output pri_e pri_o
);

   localparam int                WCNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

   pri_e              pri_q, pri_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // State and wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pri_q      <= PRI_CPU;
         wait_cnt_q <= '0;
      end else begin
         pri_q      <= pri_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next wait count (saturating) and next priority; the switch to host
   // priority uses the updated count so the host wins on the very next cycle.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      pri_d      = pri_q;
      if (hst_gnt_i) begin
         wait_cnt_d = '0;
      end else if (hst_req_i && (wait_cnt_q != WAIT_MAX)) begin
         wait_cnt_d = wait_cnt_q + WCNT_W'(1);
      end
      case (pri_q)
         PRI_CPU: if (wait_cnt_d == WAIT_MAX) pri_d = PRI_HST;
         PRI_HST: if (hst_gnt_i)              pri_d = PRI_CPU;
         default: pri_d = PRI_CPU;
      endcase
   end

   assign pri_o = pri_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, 1-cycle-latency data memory between the
// CPU load/store path and the host/DMA path.
// Handshake: a requester raises req with wren/ain/din and holds them stable
// until it sees gnt in the same cycle; a granted read returns one cycle later
// as a single-cycle rvalid pulse with dout on the issuing port only.
// Optional build macro ARB_STATS_EN adds CPU-stall and host-grant counters;
// without it the stat ports are tied to 0.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_ain,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_dout,
   input  logic              hst_req,
   input  logic              hst_wren,
   input  logic [ADDR_W-1:0] hst_ain,
   input  logic [DATA_W-1:0] hst_din,
   output logic              hst_gnt,
   output logic              hst_rvalid,
   output logic [DATA_W-1:0] hst_dout,
   output logic [ADDR_W-1:0] mem_ain,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [31:0]       stat_cpu_stall,
   output logic [31:0]       stat_hst_gnt
);

   pri_e  pri;
   logic  rd_pend_q, rd_pend_d;
   port_e rd_owner_q, rd_owner_d;

   arb_pri_fsm #(.MAX_WAIT(MAX_WAIT)) u_pri_fsm (
      .clk       (clk),
      .rst       (rst),
      .hst_req_i (hst_req),
      .hst_gnt_i (hst_gnt),
      .pri_o     (pri)
   );

   // Same-cycle grant: the prioritised port wins a conflict.
   always_comb begin
      cpu_gnt = 1'b0;
      hst_gnt = 1'b0;
      if (pri == PRI_CPU) begin
         cpu_gnt = cpu_req;
         hst_gnt = hst_req & ~cpu_req;
      end else begin
         hst_gnt = hst_req;
         cpu_gnt = cpu_req & ~hst_req;
      end
   end

   // Steer the granted port onto the memory; idle bus is all zeros.
   always_comb begin
      mem_ain  = '0;
      mem_din  = '0;
      mem_wren = 1'b0;
      if (cpu_gnt) begin
         mem_ain  = cpu_ain >> WORD_SHIFT;
         mem_din  = cpu_din;
         mem_wren = cpu_wren;
      end else if (hst_gnt) begin
         mem_ain  = hst_ain >> WORD_SHIFT;
         mem_din  = hst_din;
         mem_wren = hst_wren;
      end
   end

   // Remember whether a read was issued this cycle and by whom.
   always_comb begin
      rd_pend_d  = (cpu_gnt & ~cpu_wren) | (hst_gnt & ~hst_wren);
      rd_owner_d = rd_owner_q;
      if (cpu_gnt && !cpu_wren) begin
         rd_owner_d = PORT_CPU;
      end else if (hst_gnt && !hst_wren) begin
         rd_owner_d = PORT_HST;
      end
   end

   // Read-return tracking registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= PORT_CPU;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Return data to the owner only; rst suppresses a return already in flight
   // so a read interrupted by reset never shows up.
   always_comb begin
      cpu_rvalid = rd_pend_q & ~rst & (rd_owner_q == PORT_CPU);
      hst_rvalid = rd_pend_q & ~rst & (rd_owner_q == PORT_HST);
      cpu_dout   = cpu_rvalid ? mem_dout : '0;
      hst_dout   = hst_rvalid ? mem_dout : '0;
   end

`ifdef ARB_STATS_EN
   logic [31:0] stall_cnt_q, hgnt_cnt_q;

   // Wrapping counters of CPU stall cycles and host grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         hgnt_cnt_q  <= '0;
      end else begin
         if (cpu_req && !cpu_gnt) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (hst_gnt)             hgnt_cnt_q  <= hgnt_cnt_q + 32'd1;
      end
   end

   assign stat_cpu_stall = stall_cnt_q;
   assign stat_hst_gnt   = hgnt_cnt_q;
`else
   assign stat_cpu_stall = '0;
   assign stat_hst_gnt   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by constrained
// random traffic, all compared against a behavioural model of the arbiter.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_wren, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_ain;
  logic [DATA_W-1:0] cpu_din, cpu_dout;
  logic              hst_req, hst_wren, hst_gnt, hst_rvalid;
  logic [ADDR_W-1:0] hst_ain;
  logic [DATA_W-1:0] hst_din, hst_dout;
  logic [ADDR_W-1:0] mem_ain;
  logic [DATA_W-1:0] mem_din;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_dout;
  logic [31:0]       stat_cpu_stall, stat_hst_gnt;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_ain(cpu_ain), .cpu_din(cpu_din),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
    .hst_req(hst_req), .hst_wren(hst_wren), .hst_ain(hst_ain), .hst_din(hst_din),
    .hst_gnt(hst_gnt), .hst_rvalid(hst_rvalid), .hst_dout(hst_dout),
    .mem_ain(mem_ain), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout),
    .stat_cpu_stall(stat_cpu_stall), .stat_hst_gnt(stat_hst_gnt)
  );

  // Memory: synchronous read, read-before-write, 256 words.
  logic [63:0] mem_arr [256];
  always @(posedge clk) begin
    mem_dout <= mem_arr[mem_ain[7:0]];
    if (mem_wren) mem_arr[mem_ain[7:0]] <= mem_din;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        owner;   // 0 = CPU, 1 = host
    logic [63:0] data;
  } rd_t;

  rd_t         exp_q[$];
  logic [63:0] ref_mem [256];
  int          m_streak;  // consecutive cycles the host has been refused
  bit          m_hpri;    // host currently has priority
  int          m_stall, m_hgnt, h_wait;
  logic        last_cg, last_hg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_streak = 0; m_hpri = 0; m_stall = 0; m_hgnt = 0; h_wait = 0;
    last_cg = 0; last_hg = 0;
  endtask

  // One clock cycle: inputs already driven after a falling edge.
  task automatic cycle();
    logic        e_cg, e_hg, e_wren;
    logic [63:0] e_ain, e_din;
    logic [7:0]  ci, hi;
    rd_t         r;
    #1;
    ci = 8'(cpu_ain >> 3);
    hi = 8'(hst_ain >> 3);
    if (m_hpri) begin
      e_hg = hst_req; e_cg = cpu_req && !hst_req;
    end else begin
      e_cg = cpu_req; e_hg = hst_req && !cpu_req;
    end
    check("cpu_gnt", 64'(cpu_gnt), 64'(e_cg));
    check("hst_gnt", 64'(hst_gnt), 64'(e_hg));
    e_ain = '0; e_din = '0; e_wren = 1'b0;
    if (e_cg) begin
      e_ain = cpu_ain >> 3; e_din = cpu_din; e_wren = cpu_wren;
    end else if (e_hg) begin
      e_ain = hst_ain >> 3; e_din = hst_din; e_wren = hst_wren;
    end
    check("mem_ain", mem_ain, e_ain);
    check("mem_din", mem_din, e_din);
    check("mem_wren", 64'(mem_wren), 64'(e_wren));
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      check("cpu_rvalid", 64'(cpu_rvalid), 64'(r.owner == 1'b0));
      check("hst_rvalid", 64'(hst_rvalid), 64'(r.owner == 1'b1));
      check("cpu_dout", cpu_dout, (r.owner == 1'b0) ? r.data : 64'h0);
      check("hst_dout", hst_dout, (r.owner == 1'b1) ? r.data : 64'h0);
    end else begin
      check("cpu_rvalid_idle", 64'(cpu_rvalid), 64'h0);
      check("hst_rvalid_idle", 64'(hst_rvalid), 64'h0);
      check("cpu_dout_idle", cpu_dout, 64'h0);
      check("hst_dout_idle", hst_dout, 64'h0);
    end
    if (hst_req) begin
      h_wait = hst_gnt ? 0 : h_wait + 1;
      check("hst_wait_bound", 64'(h_wait <= MAX_WAIT), 64'h1);
    end
    // Advance the model.
    if (e_cg && !cpu_wren) exp_q.push_back('{owner: 1'b0, data: ref_mem[ci]});
    if (e_cg &&  cpu_wren) ref_mem[ci] = cpu_din;
    if (e_hg && !hst_wren) exp_q.push_back('{owner: 1'b1, data: ref_mem[hi]});
    if (e_hg &&  hst_wren) ref_mem[hi] = hst_din;
    if (cpu_req && !e_cg) m_stall++;
    if (e_hg) m_hgnt++;
    if (e_hg) begin
      m_streak = 0; m_hpri = 0;
    end else if (hst_req) begin
      if (m_streak < MAX_WAIT) m_streak++;
      if (m_streak == MAX_WAIT) m_hpri = 1;
    end
    last_cg = cpu_gnt;
    last_hg = hst_gnt;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; hst_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic new_cpu(input logic wr);
    cpu_wren = wr;
    cpu_ain  = {$urandom, $urandom};
    cpu_din  = {$urandom, $urandom};
  endtask

  task automatic new_hst(input logic wr);
    hst_wren = wr;
    hst_ain  = {$urandom, $urandom};
    hst_din  = {$urandom, $urandom};
  endtask

  task automatic check_stats(input string tag, input int stall_exp, input int hgnt_exp);
`ifdef ARB_STATS_EN
    check({tag, "_stall"}, 64'(stat_cpu_stall), 64'(stall_exp));
    check({tag, "_hgnt"},  64'(stat_hst_gnt),   64'(hgnt_exp));
`else
    check({tag, "_stall_off"}, 64'(stat_cpu_stall), 64'h0);
    check({tag, "_hgnt_off"},  64'(stat_hst_gnt),   64'h0);
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] hg_pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h1_0001);
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8] = 64'hDEAD;
    ref_mem[8] = 64'hDEAD;
    cpu_wren = 0; cpu_ain = '0; cpu_din = '0;
    hst_wren = 0; hst_ain = '0; hst_din = '0;
    do_reset();

    // Reset state.
    #1;
    check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'h0);
    check("rst_hst_rvalid", 64'(hst_rvalid), 64'h0);
    check("rst_cpu_dout", cpu_dout, 64'h0);
    check("rst_hst_dout", hst_dout, 64'h0);
    check("rst_pri", 64'(dut.u_pri_fsm.pri_q), 64'(PRI_CPU));
    check("rst_wait", 64'(dut.u_pri_fsm.wait_cnt_q), 64'h0);
    check_stats("rst", 0, 0);
    @(negedge clk);

    // CPU read of word 8.
    cpu_req = 1; cpu_wren = 0; cpu_ain = 64'h40;
    #1;
    check("t1_cpu_gnt", 64'(cpu_gnt), 64'h1);
    check("t1_mem_ain", mem_ain, 64'h8);
    cycle();
    cpu_req = 0;
    #1;
    check("t1_cpu_rvalid", 64'(cpu_rvalid), 64'h1);
    check("t1_cpu_dout", cpu_dout, 64'hDEAD);
    check("t1_hst_dout", hst_dout, 64'h0);
    cycle();

    // Host write to byte 0x18 (word 3).
    hst_req = 1; hst_wren = 1; hst_ain = 64'h18; hst_din = 64'h55;
    #1;
    check("t2_mem_ain", mem_ain, 64'h3);
    check("t2_mem_wren", 64'(mem_wren), 64'h1);
    check("t2_mem_din", mem_din, 64'h55);
    cycle();
    hst_req = 0;
    #1;
    check("t2_no_rvalid", 64'({cpu_rvalid, hst_rvalid}), 64'h0);
    cycle();

    // Continuous contention: host wins on cycles 4 and 9.
    do_reset();
    cpu_req = 1; new_cpu(0);
    hst_req = 1; new_hst(0);
    for (int i = 0; i < 10; i++) begin
      #1;
      hg_pat[i] = hst_gnt;
      cycle();
      if (last_cg) new_cpu(0);
      if (last_hg) new_hst(0);
    end
    check("contend_pattern", 64'(hg_pat), 64'(10'b10_0001_0000));
    check_stats("contend", 2, 2);
    cpu_req = 0; hst_req = 0;
    cycle();

    // Alternating reads CPU, host, CPU, then read/write to the same word.
    cpu_req = 1; cpu_wren = 0; cpu_ain = 64'h80;  cycle(); cpu_req = 0;
    hst_req = 1; hst_wren = 0; hst_ain = 64'h88;  cycle(); hst_req = 0;
    cpu_req = 1; cpu_wren = 0; cpu_ain = 64'h90;  cycle(); cpu_req = 0;
    hst_req = 1; hst_wren = 1; hst_ain = 64'h90; hst_din = 64'h1234; cycle(); hst_req = 0;
    cpu_req = 1; cpu_wren = 0; cpu_ain = 64'h90;  cycle(); cpu_req = 0;
    #1;
    check("raw_new_data", cpu_dout, 64'h1234);
    cycle();
    cycle();

    // Reset asserted the cycle after a granted CPU read.
    cpu_req = 1; new_cpu(0);
    hst_req = 1; new_hst(0);
    cycle();
    cycle();
    cycle();
    rst = 1; cpu_req = 0; hst_req = 0;
    #1;
    check("rstrd_rvalid_a", 64'(cpu_rvalid), 64'h0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rstrd_rvalid_b", 64'(cpu_rvalid), 64'h0);
    check("rstrd_pri", 64'(dut.u_pri_fsm.pri_q), 64'(PRI_CPU));
    check("rstrd_wait", 64'(dut.u_pri_fsm.wait_cnt_q), 64'h0);
    model_reset();
    @(negedge clk);

    // Random traffic with hold-until-grant requesters.
    for (int i = 0; i < 600; i++) begin
      if (!(cpu_req && !last_cg)) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        new_cpu(1'($urandom_range(0, 1)));
      end
      if (!(hst_req && !last_hg)) begin
        hst_req = ($urandom_range(0, 1) != 0);
        new_hst(1'($urandom_range(0, 1)));
      end
      cycle();
    end
    cpu_req = 0; hst_req = 0;
    cycle();
    check_stats("random", m_stall, m_hgnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
